// File: rtl/logic_proc_pkg.sv
// logic_proc_pkg
//   Shared types and constants for the logic Processor command driver.
//   cmd_op_t    : command opcodes carried on cmd_op
//   drv_state_t : driver sequencing states
//   max3()      : elaboration-time helper for sizing the phase counter
package logic_proc_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOADA = 2'b01,
        OP_LOADB = 2'b10,
        OP_EXEC  = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        SETTLE = 2'b10,
        RESP   = 2'b11
    } drv_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/logic_proc_cmd_driver_phase_down_counter.sv
// phase_down_counter
//   Down-counter timing one FSM phase. A load strobe sets the count; dec
//   steps it toward zero and it parks there (it never wraps).
//   clk      in  system clock
//   reset    in  synchronous, active-high
//   load_val in  value taken on load
//   load     in  load strobe (wins over dec)
//   dec      in  decrement enable
//   zero     out count is zero
module phase_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] load_val,
    input  logic         load,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/logic_proc_cmd_driver.sv
// logic_proc_cmd_driver
//   Command-side initiator for the 8-bit bit-serial logic Processor. Takes
//   NOP/LOADA/LOADB/EXEC commands over valid/ready, drives the Processor's
//   LoadA/LoadB/Execute/Din/F/R with correct timing, waits for the result to
//   settle and returns Aval/Bval as a one-cycle response.
//
//   Clk, Reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/din/f/r        opcode and operands
//   rsp_valid/rsp_a/rsp_b one-cycle response with sampled A/B
//   busy                  inverse of cmd_ready
//   LoadA/LoadB/Execute   Processor controls (Execute active-low)
//   Din/F/R               Processor operands, held between accepts
//   Aval/Bval             Processor register contents
//
//   state  | meaning
//   IDLE   | ready for a command
//   DRIVE  | control pulse active (LoadA, LoadB or Execute low)
//   SETTLE | controls released, Processor re-arms / results settle
//   RESP   | rsp_valid high for one cycle
module logic_proc_cmd_driver
    import logic_proc_pkg::*;
#(
    parameter int PULSE_CYCLES = 1,
    parameter int EXEC_CYCLES  = 12,
    parameter int GAP_CYCLES   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_din,
    input  logic [2:0]        cmd_f,
    input  logic [1:0]        cmd_r,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              busy,
    output logic              LoadA,
    output logic              LoadB,
    output logic              Execute,
    output logic [DATA_W-1:0] Din,
    output logic [2:0]        F,
    output logic [1:0]        R,
    input  logic [DATA_W-1:0] Aval,
    input  logic [DATA_W-1:0] Bval
);

    localparam int CNT_W = $clog2(max3(PULSE_CYCLES, EXEC_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

    drv_state_t        state_q, state_d;
    logic              loada_q, loada_d;
    logic              loadb_q, loadb_d;
    logic              exec_n_q, exec_n_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [2:0]        f_q, f_d;
    logic [1:0]        r_q, r_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0] rsp_b_q, rsp_b_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    phase_down_counter #(.W(CNT_W)) u_phase_cnt (
        .clk      (Clk),
        .reset    (Reset),
        .load_val (cnt_val),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Controls are registered so the Processor sees clean, edge-aligned
    // pulses; the opcode itself only needs to live until the DRIVE decision.
    always_comb begin
        state_d  = state_q;
        loada_d  = loada_q;
        loadb_d  = loadb_q;
        exec_n_d = exec_n_q;
        din_d    = din_q;
        f_d      = f_q;
        r_d      = r_q;
        rsp_a_d  = rsp_a_q;
        rsp_b_d  = rsp_b_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    din_d = cmd_din;
                    f_d   = cmd_f;
                    r_d   = cmd_r;
                    case (cmd_op_t'(cmd_op))
                        OP_NOP: begin
                            rsp_a_d = Aval;
                            rsp_b_d = Bval;
                            state_d = RESP;
                        end
                        OP_LOADA: begin
                            loada_d  = 1'b1;
                            cnt_load = 1'b1;
                            cnt_val  = PULSE_LD;
                            state_d  = DRIVE;
                        end
                        OP_LOADB: begin
                            loadb_d  = 1'b1;
                            cnt_load = 1'b1;
                            cnt_val  = PULSE_LD;
                            state_d  = DRIVE;
                        end
                        OP_EXEC: begin
                            exec_n_d = 1'b0;
                            cnt_load = 1'b1;
                            cnt_val  = EXEC_LD;
                            state_d  = DRIVE;
                        end
                        default: ;
                    endcase
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    loada_d  = 1'b0;
                    loadb_d  = 1'b0;
                    exec_n_d = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = GAP_LD;
                    state_d  = SETTLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    rsp_a_d = Aval;
                    rsp_b_d = Bval;
                    state_d = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            loada_q  <= 1'b0;
            loadb_q  <= 1'b0;
            exec_n_q <= 1'b1;
            din_q    <= '0;
            f_q      <= '0;
            r_q      <= '0;
            rsp_a_q  <= '0;
            rsp_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            loada_q  <= loada_d;
            loadb_q  <= loadb_d;
            exec_n_q <= exec_n_d;
            din_q    <= din_d;
            f_q      <= f_d;
            r_q      <= r_d;
            rsp_a_q  <= rsp_a_d;
            rsp_b_q  <= rsp_b_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign LoadA     = loada_q;
    assign LoadB     = loadb_q;
    assign Execute   = exec_n_q;
    assign Din       = din_q;
    assign F         = f_q;
    assign R         = r_q;

endmodule

// File: tb/tb_logic_proc_cmd_driver.sv
// Bench for logic_proc_cmd_driver with a behavioural logic Processor attached.
module tb_logic_proc_cmd_driver;
    import logic_proc_pkg::*;

    localparam int P = 1;
    localparam int E = 12;
    localparam int G = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_din = 8'h00;
    logic [2:0] cmd_f = 3'b000;
    logic [1:0] cmd_r = 2'b00;
    logic       rsp_valid;
    logic [7:0] rsp_a, rsp_b;
    logic       busy;
    logic       LoadA, LoadB, Execute;
    logic [7:0] Din;
    logic [2:0] F;
    logic [1:0] R;
    logic [7:0] Aval, Bval;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    logic_proc_cmd_driver #(.PULSE_CYCLES(P), .EXEC_CYCLES(E), .GAP_CYCLES(G)) dut (
        .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_din(cmd_din), .cmd_f(cmd_f), .cmd_r(cmd_r),
        .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b), .busy(busy),
        .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute), .Din(Din), .F(F), .R(R),
        .Aval(Aval), .Bval(Bval)
    );

    // Processor logic function table
    function automatic logic [7:0] fn(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return 8'hFF;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural Processor: loads on LoadA/LoadB, computes once after eight
    // cycles of Execute low (the serial shift), re-arms when Execute goes high.
    logic [7:0] proc_a = 8'h00;
    logic [7:0] proc_b = 8'h00;
    int         ex_cnt = 0;
    assign Aval = proc_a;
    assign Bval = proc_b;

    always @(posedge Clk) begin
        logic [7:0] res;
        if (LoadA) proc_a <= Din;
        if (LoadB) proc_b <= Din;
        if (!Execute) begin
            if (ex_cnt == 7) begin
                res = fn(F, proc_a, proc_b);
                case (R)
                    2'b01: proc_b <= res;
                    2'b10: proc_a <= res;
                    2'b11: begin proc_a <= proc_b; proc_b <= proc_a; end
                    default: ;
                endcase
            end
            ex_cnt <= ex_cnt + 1;
        end else begin
            ex_cnt <= 0;
        end
    end

    int n_acc = 0;
    always @(posedge Clk) begin
        if (!Reset && cmd_valid && cmd_ready) n_acc = n_acc + 1;
    end

    int hi_run = 0;
    int min_gap = 1000;
    bit seen_low = 1'b0;
    always @(negedge Clk) begin
        if (Execute) begin
            hi_run = hi_run + 1;
        end else begin
            if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            seen_low = 1'b1;
            hi_run = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, holding cmd_valid until the response like a host
    // would. Returns response data, accept-to-response latency and the
    // number of cycles each control was active.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] din, input logic [2:0] f,
                          input logic [1:0] r, output logic [7:0] ra, output logic [7:0] rb,
                          output int lat, output int la, output int lb, output int ex,
                          output bit stable, output bit tmo);
        int w;
        bit got;
        ra = 8'h00; rb = 8'h00; lat = 0; la = 0; lb = 0; ex = 0;
        stable = 1'b1; tmo = 1'b0; got = 1'b0;
        @(negedge Clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_din = din; cmd_f = f; cmd_r = r;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge Clk);
            w++;
        end
        if (!cmd_ready) begin
            tmo = 1'b1;
            cmd_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        while (!got && lat < 100) begin
            @(negedge Clk);
            lat++;
            if (LoadA) la++;
            if (LoadB) lb++;
            if (!Execute) ex++;
            if (Din !== din || F !== f || R !== r) stable = 1'b0;
            if (rsp_valid) begin
                ra = rsp_a;
                rb = rsp_b;
                got = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        cmd_din = $urandom;
        cmd_f = 3'($urandom);
        cmd_r = 2'($urandom);
        if (!got) tmo = 1'b1;
    endtask

    logic [7:0] ra, rb;
    int lat, la, lb, ex;
    bit stable, tmo;
    logic [7:0] exp_a, exp_b, res;
    int acc0, rsp_seen;
    logic [1:0] op;
    logic [7:0] din;
    logic [2:0] f;
    logic [1:0] r;

    initial begin
        exp_a = 8'h00;
        exp_b = 8'h00;

        // Reset held for three cycles
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_execute", Execute, 1);
        chk("rst_loada", LoadA, 0);
        chk("rst_loadb", LoadB, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_a", rsp_a, 0);
        chk("rst_din", Din, 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);

        // LOADA / LOADB
        acc0 = n_acc;
        do_cmd(OP_LOADA, 8'h33, 3'b000, 2'b00, ra, rb, lat, la, lb, ex, stable, tmo);
        exp_a = 8'h33;
        chk("loada_tmo", tmo, 0);
        chk("loada_pulse", la, P);
        chk("loada_lat", lat, P + G + 1);
        do_cmd(OP_LOADB, 8'h55, 3'b000, 2'b00, ra, rb, lat, la, lb, ex, stable, tmo);
        exp_b = 8'h55;
        chk("loadb_pulse", lb, P);
        chk("loadb_rsp_a", ra, 8'h33);
        chk("loadb_rsp_b", rb, 8'h55);
        chk("loadb_busy_in_resp", busy, 1);
        @(negedge Clk);
        chk("ready_after_resp", cmd_ready, 1);

        // EXEC f=XOR, result to A
        do_cmd(OP_EXEC, 8'h00, 3'b010, 2'b10, ra, rb, lat, la, lb, ex, stable, tmo);
        chk("exec1_low_cycles", ex, E);
        chk("exec1_lat", lat, E + G + 1);
        chk("exec1_rsp_a", ra, 8'h66);
        chk("exec1_rsp_b", rb, 8'h55);

        // EXEC f=XNOR to B, then swap, back to back
        do_cmd(OP_EXEC, 8'h00, 3'b110, 2'b01, ra, rb, lat, la, lb, ex, stable, tmo);
        chk("exec2_rsp_a", ra, 8'h66);
        chk("exec2_rsp_b", rb, 8'hCC);
        do_cmd(OP_EXEC, 8'h00, 3'b000, 2'b11, ra, rb, lat, la, lb, ex, stable, tmo);
        chk("swap_rsp_a", ra, 8'hCC);
        chk("swap_rsp_b", rb, 8'h66);
        chk("min_exec_gap", min_gap, G + 2);
        exp_a = 8'hCC;
        exp_b = 8'h66;

        // NOP
        do_cmd(OP_NOP, 8'hA5, 3'b101, 2'b01, ra, rb, lat, la, lb, ex, stable, tmo);
        chk("nop_lat", lat, 1);
        chk("nop_rsp_a", ra, exp_a);
        chk("nop_rsp_b", rb, exp_b);
        chk("nop_din_captured", stable, 1);
        chk("accepts_directed", n_acc - acc0, 6);

        // Randomized commands against the reference model
        acc0 = n_acc;
        for (int i = 0; i < 30; i++) begin
            op  = 2'($urandom_range(0, 3));
            din = 8'($urandom);
            f   = 3'($urandom);
            r   = 2'($urandom);
            do_cmd(op, din, f, r, ra, rb, lat, la, lb, ex, stable, tmo);
            case (op)
                2'b01: exp_a = din;
                2'b10: exp_b = din;
                2'b11: begin
                    res = fn(f, exp_a, exp_b);
                    case (r)
                        2'b01: exp_b = res;
                        2'b10: exp_a = res;
                        2'b11: begin res = exp_a; exp_a = exp_b; exp_b = res; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
            chk("rnd_tmo", tmo, 0);
            chk("rnd_rsp_a", ra, exp_a);
            chk("rnd_rsp_b", rb, exp_b);
            chk("rnd_lat", lat, (op == 2'b00) ? 1 : (op == 2'b11) ? E + G + 1 : P + G + 1);
            chk("rnd_loada", la, (op == 2'b01) ? P : 0);
            chk("rnd_loadb", lb, (op == 2'b10) ? P : 0);
            chk("rnd_exec", ex, (op == 2'b11) ? E : 0);
            chk("rnd_stable", stable, 1);
        end
        chk("accepts_random", n_acc - acc0, 30);
        chk("min_exec_gap_rnd", (min_gap >= G + 2) ? 1 : 0, 1);

        // Reset in the fifth DRIVE cycle of an EXEC
        @(negedge Clk);
        cmd_valid = 1'b1; cmd_op = OP_EXEC; cmd_f = 3'b011; cmd_r = 2'b10;
        @(posedge Clk);
        repeat (5) @(negedge Clk);
        chk("abort_exec_low", Execute, 0);
        Reset = 1'b1;
        cmd_valid = 1'b0;
        rsp_seen = 0;
        @(negedge Clk);
        chk("abort_execute_high", Execute, 1);
        chk("abort_loada", LoadA, 0);
        if (rsp_valid) rsp_seen++;
        @(negedge Clk);
        if (rsp_valid) rsp_seen++;
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_ready", cmd_ready, 1);
        repeat (16) begin
            if (rsp_valid) rsp_seen++;
            @(negedge Clk);
        end
        chk("abort_no_rsp", rsp_seen, 0);
        do_cmd(OP_NOP, 8'h00, 3'b000, 2'b00, ra, rb, lat, la, lb, ex, stable, tmo);
        chk("abort_a_unchanged", ra, exp_a);
        chk("abort_b_unchanged", rb, exp_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
